unsat_clause_selector: RTL and testbench

- Responder to the solver controller's unsat-clause-select request (UCS_REQUEST, control bit 0).
- Buffers the clause indices written during the gather pass (controller FIFO_WR_EN, bit 2).
- On each request, returns one buffered clause chosen pseudo-randomly with a 16-bit LFSR, or reports that no unsat clause exists (formula satisfied).
- Sits between the clause-evaluation datapath and the variable-flip stage.

---
 rtl/unsat_clause_selector.sv | 180 ++++++++++++++++++
 tb/tb_unsat_clause_selector.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unsat_clause_selector.sv
`default_nettype none
// ============================================================================
// Module   : unsat_clause_selector
// Brief    : Buffers unsat clause indices and returns one chosen by a 16-bit
//            Galois LFSR, or reports that none exist.
// Revision : 1.0 - initial release
// ============================================================================
module unsat_clause_selector #(
    parameter int          CLAUSE_IDX_W = 10,
    parameter int          DEPTH        = 64,
    parameter int          AW           = $clog2(DEPTH),
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    wr_en,
    input  logic [CLAUSE_IDX_W-1:0] wr_clause,
    input  logic                    seed_load,
    input  logic [15:0]             seed_i,
    input  logic                    req,
    output logic                    busy,
    output logic                    sel_valid,
    output logic                    sel_none,
    output logic [CLAUSE_IDX_W-1:0] sel_clause,
    output logic [AW:0]             count,
    output logic                    full,
    output logic                    overflow
);

    localparam logic [AW:0] C_FULL     = (AW+1)'(DEPTH);
    localparam logic [15:0] C_LFSR_TAP = 16'hB400;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PICK = 2'd1,
        S_READ = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    logic [CLAUSE_IDX_W-1:0] mem [DEPTH];
    logic [CLAUSE_IDX_W-1:0] r_rdata;
    logic [AW:0]             r_count;
    logic [AW:0]             r_snap;
    logic [AW:0]             r_idx;
    logic [15:0]             r_lfsr;
    logic [15:0]             w_lfsr_next;

    logic                    w_accept;
    logic                    w_idx_sub;
    logic                    w_rd_en;
    logic                    w_load_clause;
    logic                    w_resp_none;
    logic                    w_resp_enter;
    logic                    w_wr_fire;

    assign count       = r_count;
    assign full        = (r_count == C_FULL);
    assign busy        = (r_state != S_IDLE);
    assign sel_valid   = (r_state == S_RESP);
    assign w_wr_fire   = wr_en & ~clear & ~full;
    assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? C_LFSR_TAP : 16'h0000);
    assign w_resp_enter = (w_state_next == S_RESP) && (r_state != S_RESP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_accept      = 1'b0;
        w_idx_sub     = 1'b0;
        w_rd_en       = 1'b0;
        w_load_clause = 1'b0;
        w_resp_none   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A clear arriving with the request empties the buffer, so it
                // is answered as the empty case rather than reading stale data.
                if (req) begin
                    if ((r_count == '0) || clear) begin
                        w_state_next = S_RESP;
                        w_resp_none  = 1'b1;
                    end else begin
                        w_state_next = S_PICK;
                        w_accept     = 1'b1;
                    end
                end
            end
            S_PICK: begin
                if (clear) begin
                    w_state_next = S_RESP;
                    w_resp_none  = 1'b1;
                end else if (r_idx >= r_snap) begin
                    w_idx_sub = 1'b1;
                end else begin
                    w_rd_en      = 1'b1;
                    w_state_next = S_READ;
                end
            end
            S_READ: begin
                w_state_next = S_RESP;
                if (clear) begin
                    w_resp_none = 1'b1;
                end else begin
                    w_load_clause = 1'b1;
                end
            end
            S_RESP: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count    <= '0;
            overflow   <= 1'b0;
            r_lfsr     <= LFSR_SEED;
            r_snap     <= '0;
            r_idx      <= '0;
            sel_clause <= '0;
            sel_none   <= 1'b0;
        end else begin
            if (clear) begin
                r_count  <= '0;
                overflow <= 1'b0;
            end else if (wr_en) begin
                if (full) begin
                    overflow <= 1'b1;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end

            if (seed_load) begin
                r_lfsr <= (seed_i == 16'h0000) ? LFSR_SEED : seed_i;
            end else if (w_accept) begin
                r_lfsr <= w_lfsr_next;
            end

            // Repeated subtraction leaves idx = lfsr[AW-1:0] mod snap.
            if (w_accept) begin
                r_snap <= r_count;
                r_idx  <= {1'b0, r_lfsr[AW-1:0]};
            end else if (w_idx_sub) begin
                r_idx <= r_idx - r_snap;
            end

            if (w_load_clause) begin
                sel_clause <= r_rdata;
            end
            if (w_resp_enter) begin
                sel_none <= w_resp_none;
            end
        end
    end

    // Read address is below snap, so it never aliases the write slot.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            mem[r_count[AW-1:0]] <= wr_clause;
        end
        if (w_rd_en) begin
            r_rdata <= mem[r_idx[AW-1:0]];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_unsat_clause_selector.sv
`default_nettype none
// ============================================================================
// Module   : tb_unsat_clause_selector
// Brief    : Self-checking bench for unsat_clause_selector against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_unsat_clause_selector;

    localparam int          W     = 10;
    localparam int          DEPTH = 64;
    localparam int          AW    = 6;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clear = 1'b0;
    logic          wr_en = 1'b0;
    logic [W-1:0]  wr_clause = '0;
    logic          seed_load = 1'b0;
    logic [15:0]   seed_i = '0;
    logic          req = 1'b0;
    logic          busy;
    logic          sel_valid;
    logic          sel_none;
    logic [W-1:0]  sel_clause;
    logic [AW:0]   count;
    logic          full;
    logic          overflow;

    unsat_clause_selector #(
        .CLAUSE_IDX_W (W),
        .DEPTH        (DEPTH),
        .AW           (AW),
        .LFSR_SEED    (SEED)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .wr_en      (wr_en),
        .wr_clause  (wr_clause),
        .seed_load  (seed_load),
        .seed_i     (seed_i),
        .req        (req),
        .busy       (busy),
        .sel_valid  (sel_valid),
        .sel_none   (sel_none),
        .sel_clause (sel_clause),
        .count      (count),
        .full       (full),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a plain list of stored clauses plus the LFSR value.
    int unsigned m_q[$];
    bit          m_ovf  = 1'b0;
    logic [15:0] m_lfsr = SEED;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return (x >> 1) ^ ((x % 2 == 1) ? 16'hB400 : 16'h0000);
    endfunction

    task automatic m_write(input int unsigned v);
        if (m_q.size() < DEPTH) m_q.push_back(v);
        else m_ovf = 1'b1;
    endtask

    task automatic m_reset_state();
        m_q.delete();
        m_ovf = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [W-1:0] v);
        wr_en = 1'b1;
        wr_clause = v;
        tick();
        wr_en = 1'b0;
        m_write(32'(v));
    endtask

    task automatic check_status(input string tag);
        check({tag, ".count"}, 32'(count), 32'(m_q.size()));
        check({tag, ".full"}, 32'(full), 32'(m_q.size() == DEPTH));
        check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    endtask

    task automatic do_clear(input bit with_wr);
        clear = 1'b1;
        wr_en = with_wr;
        wr_clause = 10'($urandom);
        tick();
        clear = 1'b0;
        wr_en = 1'b0;
        m_reset_state();
    endtask

    task automatic do_seed(input logic [15:0] s);
        seed_load = 1'b1;
        seed_i = s;
        tick();
        seed_load = 1'b0;
        m_lfsr = (s == 16'h0000) ? SEED : s;
    endtask

    // One full request; noisy adds concurrent writes and a stray mid-flight req.
    task automatic do_req(input bit noisy, output int lat, output logic [W-1:0] clause,
                          output logic none);
        int          exp_lat;
        int unsigned exp_clause;
        bit          exp_none;
        int          busy_bad;
        int          stray;
        int unsigned low;
        int unsigned snap;
        exp_clause = 0;
        if (m_q.size() == 0) begin
            exp_none = 1'b1;
            exp_lat  = 1;
        end else begin
            exp_none   = 1'b0;
            snap       = m_q.size();
            low        = 32'(m_lfsr) % 64;
            exp_lat    = 3 + int'(low / snap);
            exp_clause = m_q[low % snap];
            m_lfsr     = lfsr_step(m_lfsr);
        end
        req = 1'b1;
        tick();
        req = 1'b0;
        lat = 0;
        busy_bad = 0;
        for (int k = 1; k <= 200; k++) begin
            if (!busy) busy_bad++;
            if (sel_valid) begin
                lat = k;
                break;
            end
            if (noisy) begin
                req = (k == 2);
                wr_en = 1'($urandom_range(0, 1));
                wr_clause = 10'($urandom);
            end
            tick();
            if (noisy && wr_en) m_write(32'(wr_clause));
        end
        wr_en = 1'b0;
        req = 1'b0;
        clause = sel_clause;
        none = sel_none;
        check("req.latency", 32'(lat), 32'(exp_lat));
        check("req.none", 32'(sel_none), 32'(exp_none));
        if (!exp_none) check("req.clause", 32'(sel_clause), exp_clause);
        check("req.busy_during", 32'(busy_bad), 32'd0);
        stray = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (sel_valid) stray++;
        end
        check("req.single_strobe", 32'(stray), 32'd0);
        check("req.none_held", 32'(sel_none), 32'(none));
        check("req.clause_held", 32'(sel_clause), 32'(clause));
    endtask

    initial begin
        int           lat;
        logic [W-1:0] clause;
        logic         none;
        int           subs;
        int           hits;
        int           n_wr;
        logic [W-1:0] wr_list [5];
        wr_list[0] = 10'd5;
        wr_list[1] = 10'd17;
        wr_list[2] = 10'd42;
        wr_list[3] = 10'd99;
        wr_list[4] = 10'd200;

        tick();
        tick();
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.valid", 32'(sel_valid), 32'd0);
        check("rst.none", 32'(sel_none), 32'd0);
        check("rst.clause", 32'(sel_clause), 32'd0);
        check_status("rst");
        rst = 1'b1;
        tick();

        // Directed: five entries, two requests, both land on index 3
        for (int i = 0; i < 5; i++) write_word(wr_list[i]);
        check_status("fill5");
        do_req(1'b0, lat, clause, none);
        check("first.latency9", 32'(lat), 32'd9);
        check("first.clause99", 32'(clause), 32'd99);
        check("first.none0", 32'(none), 32'd0);
        do_req(1'b1, lat, clause, none);
        check("second.clause99", 32'(clause), 32'd99);

        do_clear(1'b0);
        do_req(1'b0, lat, clause, none);
        check("empty.none1", 32'(none), 32'd1);
        check("empty.latency1", 32'(lat), 32'd1);
        check_status("empty");

        // Overflow boundary
        for (int i = 0; i < 65; i++) begin
            write_word(10'(i * 7 + 3));
            if (i == 63) check("full.after64", 32'(full), 32'd1);
            if (i == 62) check("full.before64", 32'(full), 32'd0);
        end
        check_status("overflow");
        do_clear(1'b1);
        check_status("clear_with_wr");

        // Zero seed falls back to the reset seed, so index 3 again
        do_seed(16'h0000);
        for (int i = 0; i < 5; i++) write_word(wr_list[i]);
        do_req(1'b0, lat, clause, none);
        check("seed0.clause99", 32'(clause), 32'd99);
        do_clear(1'b0);
        do_seed(16'h0001);
        for (int i = 0; i < 8; i++) write_word(10'(i));
        do_req(1'b0, lat, clause, none);
        check("seed1.clause1", 32'(clause), 32'd1);
        check("seed1.latency3", 32'(lat), 32'd3);

        // Clear during PICK: exactly one empty response
        do_clear(1'b0);
        for (int i = 0; i < 5; i++) write_word(wr_list[i]);
        m_lfsr = lfsr_step(m_lfsr);
        req = 1'b1;
        tick();
        req = 1'b0;
        check("pickclr.busy", 32'(busy), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        m_reset_state();
        check("pickclr.valid", 32'(sel_valid), 32'd1);
        check("pickclr.none", 32'(sel_none), 32'd1);
        hits = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (sel_valid) hits++;
        end
        check("pickclr.single", 32'(hits), 32'd0);
        check_status("pickclr");

        // Reset asserted while in READ
        for (int i = 0; i < 5; i++) write_word(wr_list[i]);
        subs = int'((32'(m_lfsr) % 64) / 5);
        req = 1'b1;
        tick();
        req = 1'b0;
        for (int k = 0; k <= subs; k++) tick();
        rst = 1'b0;
        #1;
        check("rstread.busy", 32'(busy), 32'd0);
        check("rstread.valid", 32'(sel_valid), 32'd0);
        check("rstread.none", 32'(sel_none), 32'd0);
        check("rstread.clause", 32'(sel_clause), 32'd0);
        m_reset_state();
        m_lfsr = SEED;
        check_status("rstread");
        tick();
        rst = 1'b1;
        hits = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (sel_valid) hits++;
        end
        check("rstread.no_resp", 32'(hits), 32'd0);

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 9))
                0: do_clear(1'($urandom_range(0, 1)));
                1: do_seed(($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom));
                default: ;
            endcase
            n_wr = ($urandom_range(0, 7) == 0) ? 40 : int'($urandom_range(0, 12));
            for (int i = 0; i < n_wr; i++) write_word(10'($urandom));
            check_status("rand");
            do_req(1'($urandom_range(0, 1)), lat, clause, none);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
